// File: rtl/dla_ape_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dla_ape_ctrl
//  Description : APE job controller. Accepts a go pulse with staged job
//                fields and runs one element-wise job over the global buffer
//                (GB): read A (and B), compute in 16-bit fixed point, write
//                back. Reports busy, a done pulse and dropped-go pulses.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                 clock, synchronous active-high reset
//    go_comp_ape              job start pulse
//    stgr_ape_gb_addr_sa/sb/d source A / source B / destination base address
//    stgr_ape_len             element count
//    stgr_ape_imm             immediate operand (IMMADD / IMMMUL)
//    stgr_ape_mode            0 ELEADD, 1 ELEMUL, 2 IMMADD, 3 IMMMUL,
//                             4 ACTFUNC (ReLU); 5..7 behave as ACTFUNC
//    gb_ren/gb_raddr/gb_rdata GB read port, data valid 1 cycle after ren
//    gb_wen/gb_waddr/gb_wdata GB write request, held until gb_wgnt
//    gb_wgnt                  GB write grant
//    ape_busy, ape_done       job status, done is a one-cycle pulse
//    ape_go_drop              one-cycle pulse for a go received while busy
//    ape_perf_cycles          busy-cycle counter (zero unless enabled)
//  Build option
//    APE_PERF_CNT_EN          enables the 32-bit saturating busy-cycle counter
// ============================================================================
module dla_ape_ctrl #(
    parameter int DW   = 16,
    parameter int AW   = 13,
    parameter int FRAC = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go_comp_ape,
    input  logic [AW-1:0] stgr_ape_gb_addr_sa,
    input  logic [AW-1:0] stgr_ape_gb_addr_sb,
    input  logic [AW-1:0] stgr_ape_gb_addr_d,
    input  logic [AW-1:0] stgr_ape_len,
    input  logic [DW-1:0] stgr_ape_imm,
    input  logic [2:0]    stgr_ape_mode,
    output logic          gb_ren,
    output logic [AW-1:0] gb_raddr,
    input  logic [DW-1:0] gb_rdata,
    output logic          gb_wen,
    output logic [AW-1:0] gb_waddr,
    output logic [DW-1:0] gb_wdata,
    input  logic          gb_wgnt,
    output logic          ape_busy,
    output logic          ape_done,
    output logic          ape_go_drop,
    output logic [31:0]   ape_perf_cycles
);

    localparam logic [2:0] MODE_ELEADD = 3'd0;
    localparam logic [2:0] MODE_ELEMUL = 3'd1;
    localparam logic [2:0] MODE_IMMADD = 3'd2;
    localparam logic [2:0] MODE_IMMMUL = 3'd3;

    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RDA  = 3'd1,
        ST_RDB  = 3'd2,
        ST_CAP  = 3'd3,
        ST_WR   = 3'd4,
        ST_FIN  = 3'd5
    } state_e;

    state_e        state_q;
    logic [AW-1:0] sa_q, sb_q, d_q, len_q, idx_q;
    logic [DW-1:0] imm_q, opa_q, res_q;
    logic [2:0]    mode_q;
    logic          ren_q, wen_q, busy_q, done_q, drop_q;
    logic [AW-1:0] raddr_q, waddr_q;

    logic                   ele_mode;
    logic [DW-1:0]          op_a, op_b, res_d;
    logic signed [DW:0]     sum;
    logic signed [2*DW-1:0] prod, prod_sh;
    logic [AW-1:0]          idx_d;
    logic                   last_elem;

    assign ele_mode  = (mode_q == MODE_ELEADD) || (mode_q == MODE_ELEMUL);
    // In CAP the operand still on gb_rdata is B for ELE modes and A otherwise.
    assign op_a      = ele_mode ? opa_q : gb_rdata;
    assign op_b      = ele_mode ? gb_rdata : imm_q;
    assign idx_d     = idx_q + {{(AW-1){1'b0}}, 1'b1};
    // idx == len-1 expressed without the subtract; len is non-zero here.
    assign last_elem = (idx_d == len_q);

    always_comb begin
        sum     = $signed({op_a[DW-1], op_a}) + $signed({op_b[DW-1], op_b});
        prod    = $signed(op_a) * $signed(op_b);
        // Arithmetic shift rounds toward -inf.
        prod_sh = prod >>> FRAC;
        res_d   = op_a;
        case (mode_q)
            MODE_ELEADD, MODE_IMMADD: begin
                if (sum[DW] != sum[DW-1]) begin
                    res_d = sum[DW] ? SAT_MIN : SAT_MAX;
                end else begin
                    res_d = sum[DW-1:0];
                end
            end
            MODE_ELEMUL, MODE_IMMMUL: begin
                // Fits in DW bits only when all bits from DW-1 upward agree.
                if (!(&prod_sh[2*DW-1:DW-1]) && (|prod_sh[2*DW-1:DW-1])) begin
                    res_d = prod_sh[2*DW-1] ? SAT_MIN : SAT_MAX;
                end else begin
                    res_d = prod_sh[DW-1:0];
                end
            end
            default: begin
                res_d = op_a[DW-1] ? '0 : op_a;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            d_q     <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            imm_q   <= '0;
            mode_q  <= '0;
            opa_q   <= '0;
            res_q   <= '0;
            ren_q   <= 1'b0;
            raddr_q <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            ren_q  <= 1'b0;
            done_q <= 1'b0;
            drop_q <= go_comp_ape && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (go_comp_ape) begin
                        sa_q   <= stgr_ape_gb_addr_sa;
                        sb_q   <= stgr_ape_gb_addr_sb;
                        d_q    <= stgr_ape_gb_addr_d;
                        len_q  <= stgr_ape_len;
                        imm_q  <= stgr_ape_imm;
                        mode_q <= stgr_ape_mode;
                        idx_q  <= '0;
                        busy_q <= 1'b1;
                        if (stgr_ape_len == '0) begin
                            state_q <= ST_FIN;
                        end else begin
                            state_q <= ST_RDA;
                            ren_q   <= 1'b1;
                            raddr_q <= stgr_ape_gb_addr_sa;
                        end
                    end
                end
                ST_RDA: begin
                    if (ele_mode) begin
                        state_q <= ST_RDB;
                        ren_q   <= 1'b1;
                        raddr_q <= sb_q + idx_q;
                    end else begin
                        state_q <= ST_CAP;
                    end
                end
                ST_RDB: begin
                    opa_q   <= gb_rdata;
                    state_q <= ST_CAP;
                end
                ST_CAP: begin
                    opa_q   <= op_a;
                    res_q   <= res_d;
                    wen_q   <= 1'b1;
                    waddr_q <= d_q + idx_q;
                    state_q <= ST_WR;
                end
                ST_WR: begin
                    // Request, address and data stay put until granted.
                    if (gb_wgnt) begin
                        wen_q <= 1'b0;
                        idx_q <= idx_d;
                        if (last_elem) begin
                            state_q <= ST_FIN;
                        end else begin
                            state_q <= ST_RDA;
                            ren_q   <= 1'b1;
                            raddr_q <= sa_q + idx_d;
                        end
                    end
                end
                ST_FIN: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gb_ren      = ren_q;
    assign gb_raddr    = raddr_q;
    assign gb_wen      = wen_q;
    assign gb_waddr    = waddr_q;
    assign gb_wdata    = res_q;
    assign ape_busy    = busy_q;
    assign ape_done    = done_q;
    assign ape_go_drop = drop_q;

`ifdef APE_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (go_comp_ape && (state_q == ST_IDLE)) begin
            perf_q <= '0;
        end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign ape_perf_cycles = perf_q;
`else
    assign ape_perf_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dla_ape_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dla_ape_ctrl
//  Description : Self-checking bench for dla_ape_ctrl with a GB memory model
//                and read/write scoreboards.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dla_ape_ctrl;

    localparam int DW   = 16;
    localparam int AW   = 13;
    localparam int FRAC = 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          go_comp_ape;
    logic [AW-1:0] stgr_ape_gb_addr_sa;
    logic [AW-1:0] stgr_ape_gb_addr_sb;
    logic [AW-1:0] stgr_ape_gb_addr_d;
    logic [AW-1:0] stgr_ape_len;
    logic [DW-1:0] stgr_ape_imm;
    logic [2:0]    stgr_ape_mode;
    logic          gb_ren;
    logic [AW-1:0] gb_raddr;
    logic [DW-1:0] gb_rdata;
    logic          gb_wen;
    logic [AW-1:0] gb_waddr;
    logic [DW-1:0] gb_wdata;
    logic          gb_wgnt;
    logic          ape_busy;
    logic          ape_done;
    logic          ape_go_drop;
    logic [31:0]   ape_perf_cycles;

    logic [DW-1:0] mem    [0:(1<<AW)-1];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic [31:0]   rd_q [$];
    wr_t           wr_q [$];

    int n_vec    = 0;
    int n_err    = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int drop_cnt = 0;

    always #5 clk = ~clk;

    dla_ape_ctrl #(.DW(DW), .AW(AW), .FRAC(FRAC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .go_comp_ape         (go_comp_ape),
        .stgr_ape_gb_addr_sa (stgr_ape_gb_addr_sa),
        .stgr_ape_gb_addr_sb (stgr_ape_gb_addr_sb),
        .stgr_ape_gb_addr_d  (stgr_ape_gb_addr_d),
        .stgr_ape_len        (stgr_ape_len),
        .stgr_ape_imm        (stgr_ape_imm),
        .stgr_ape_mode       (stgr_ape_mode),
        .gb_ren              (gb_ren),
        .gb_raddr            (gb_raddr),
        .gb_rdata            (gb_rdata),
        .gb_wen              (gb_wen),
        .gb_waddr            (gb_waddr),
        .gb_wdata            (gb_wdata),
        .gb_wgnt             (gb_wgnt),
        .ape_busy            (ape_busy),
        .ape_done            (ape_done),
        .ape_go_drop         (ape_go_drop),
        .ape_perf_cycles     (ape_perf_cycles)
    );

    // GB read port: one-cycle latency.
    always @(posedge clk) begin
        if (gb_ren) gb_rdata <= mem[gb_raddr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_op(input logic [2:0] mode, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        longint av, bv, r;
        av = longint'($signed(a));
        bv = longint'($signed(b));
        case (mode)
            3'd0, 3'd2: r = av + bv;
            3'd1, 3'd3: r = (av * bv) >>> FRAC;
            default:    r = (av < 0) ? 0 : av;
        endcase
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r[DW-1:0];
    endfunction

    task automatic set_word(input logic [AW-1:0] a, input logic [DW-1:0] v);
        mem[a]    = v;
        shadow[a] = v;
    endtask

    // Sampled at the falling edge, away from the DUT's active edge.
    task automatic monitor();
        logic [31:0] exp_a, exp_wa, exp_wd;
        if (ape_busy)    busy_cnt++;
        if (ape_done)    done_cnt++;
        if (ape_go_drop) drop_cnt++;
        if (gb_ren) begin
            if (rd_q.size() > 0) exp_a = rd_q.pop_front();
            else                 exp_a = 32'hFFFF_FFFF;
            check_val("rd_addr", 32'(gb_raddr), exp_a);
        end
        if (gb_wen) begin
            if (wr_q.size() > 0) begin
                exp_wa = 32'(wr_q[0].a);
                exp_wd = 32'(wr_q[0].d);
            end else begin
                exp_wa = 32'hFFFF_FFFF;
                exp_wd = 32'hFFFF_FFFF;
            end
            check_val("wr_addr", 32'(gb_waddr), exp_wa);
            check_val("wr_data", 32'(gb_wdata), exp_wd);
            if (gb_wgnt) begin
                if (wr_q.size() > 0) void'(wr_q.pop_front());
                mem[gb_waddr] = gb_wdata;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic prep(input logic [2:0] mode, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                        input logic [AW-1:0] d, input logic [AW-1:0] len, input logic [DW-1:0] imm);
        logic [AW-1:0] ai, bi, di;
        logic [DW-1:0] a, b, r;
        wr_t           w;
        bit            ele;
        ele = (mode == 3'd0) || (mode == 3'd1);
        for (int i = 0; i < int'(len); i++) begin
            ai = sa + AW'(i);
            bi = sb + AW'(i);
            di = d + AW'(i);
            a  = shadow[ai];
            rd_q.push_back(32'(ai));
            if (ele) begin
                b = shadow[bi];
                rd_q.push_back(32'(bi));
            end else begin
                b = imm;
            end
            r = ref_op(mode, a, b);
            shadow[di] = r;
            w.a = di;
            w.d = r;
            wr_q.push_back(w);
        end
    endtask

    task automatic launch(input logic [2:0] mode, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                          input logic [AW-1:0] d, input logic [AW-1:0] len, input logic [DW-1:0] imm);
        stgr_ape_gb_addr_sa = sa;
        stgr_ape_gb_addr_sb = sb;
        stgr_ape_gb_addr_d  = d;
        stgr_ape_len        = len;
        stgr_ape_imm        = imm;
        stgr_ape_mode       = mode;
        go_comp_ape         = 1'b1;
        tick();
        go_comp_ape         = 1'b0;
        // Staging fields change after the go; the job must not notice.
        stgr_ape_gb_addr_sa = AW'($urandom);
        stgr_ape_gb_addr_sb = AW'($urandom);
        stgr_ape_gb_addr_d  = AW'($urandom);
        stgr_ape_len        = AW'($urandom);
        stgr_ape_imm        = DW'($urandom);
        stgr_ape_mode       = 3'($urandom);
    endtask

    task automatic run_job(input logic [2:0] mode, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                           input logic [AW-1:0] d, input logic [AW-1:0] len, input logic [DW-1:0] imm,
                           input int stall_elem);
        int            n, stall_left, dn0, dr0, lat;
        logic          stray;
        logic [AW-1:0] stall_addr;
        bit            ele;
        ele        = (mode == 3'd0) || (mode == 3'd1);
        lat        = (len == '0) ? 1 : ((ele ? 4 : 3) * int'(len) + 1);
        stall_left = (stall_elem >= 0) ? 5 : 0;
        lat        = lat + stall_left;
        stall_addr = d + AW'(stall_elem);
        prep(mode, sa, sb, d, len, imm);
        busy_cnt = 0;
        dn0      = done_cnt;
        dr0      = drop_cnt;
        launch(mode, sa, sb, d, len, imm);
        check_val("busy_rise", 32'(ape_busy), 32'd1);
        n = 0;
        while (!ape_done && n < 500) begin
            stray       = 1'b0;
            gb_wgnt     = 1'b1;
            go_comp_ape = 1'b0;
            if (stall_left > 0 && gb_wen && gb_waddr == stall_addr) begin
                gb_wgnt = 1'b0;
                stall_left--;
                if (stall_left == 2) begin
                    go_comp_ape = 1'b1;
                    stray       = 1'b1;
                end
            end
            tick();
            n++;
            if (stray) check_val("go_drop_pulse", 32'(ape_go_drop), 32'd1);
        end
        go_comp_ape = 1'b0;
        gb_wgnt     = 1'b1;
        check_val("done_latency", 32'(n), 32'(lat));
        check_val("busy_at_done", 32'(ape_busy), 32'd0);
        check_val("busy_cycles", 32'(busy_cnt), 32'(lat));
`ifdef APE_PERF_CNT_EN
        check_val("perf_cycles", ape_perf_cycles, 32'(lat));
`else
        check_val("perf_tied0", ape_perf_cycles, 32'd0);
`endif
        tick();
        check_val("done_pulse_end", 32'(ape_done), 32'd0);
        check_val("done_count", 32'(done_cnt - dn0), 32'd1);
        check_val("drop_count", 32'(drop_cnt - dr0), (stall_elem >= 0) ? 32'd1 : 32'd0);
        check_val("rd_left", 32'(rd_q.size()), 32'd0);
        check_val("wr_left", 32'(wr_q.size()), 32'd0);
    endtask

    initial begin
        int n, dn0;
        rst                 = 1'b1;
        go_comp_ape         = 1'b0;
        gb_wgnt             = 1'b1;
        stgr_ape_gb_addr_sa = '0;
        stgr_ape_gb_addr_sb = '0;
        stgr_ape_gb_addr_d  = '0;
        stgr_ape_len        = '0;
        stgr_ape_imm        = '0;
        stgr_ape_mode       = '0;
        for (int i = 0; i < (1 << AW); i++) set_word(AW'(i), '0);
        repeat (3) tick();

        // Reset state
        check_val("rst_ren",   32'(gb_ren),      32'd0);
        check_val("rst_wen",   32'(gb_wen),      32'd0);
        check_val("rst_raddr", 32'(gb_raddr),    32'd0);
        check_val("rst_waddr", 32'(gb_waddr),    32'd0);
        check_val("rst_wdata", 32'(gb_wdata),    32'd0);
        check_val("rst_busy",  32'(ape_busy),    32'd0);
        check_val("rst_done",  32'(ape_done),    32'd0);
        check_val("rst_drop",  32'(ape_go_drop), 32'd0);
        check_val("rst_perf",  ape_perf_cycles,  32'd0);
        rst = 1'b0;
        tick();

        // ELEADD with positive saturation
        set_word(13'h10, 16'd1);  set_word(13'h11, 16'd2);      set_word(13'h12, 16'h7FFF);
        set_word(13'h20, 16'd3);  set_word(13'h21, 16'hFFFB);   set_word(13'h22, 16'd1);
        run_job(3'd0, 13'h10, 13'h20, 13'h30, 13'd3, 16'h0, -1);

        // IMMMUL by 1.5
        set_word(13'h40, 16'h0200); set_word(13'h41, 16'hFF00); set_word(13'h42, 16'h7000);
        run_job(3'd3, 13'h40, 13'h0, 13'h50, 13'd3, 16'h0180, -1);

        // ELEMUL with negative saturation and rounding toward -inf
        set_word(13'h60, 16'h0100); set_word(13'h61, 16'h8000); set_word(13'h62, 16'hFF80);
        set_word(13'h70, 16'h0100); set_word(13'h71, 16'h0200); set_word(13'h72, 16'h0081);
        run_job(3'd1, 13'h60, 13'h70, 13'h80, 13'd3, 16'h0, -1);

        // ReLU in place, then the same data with invalid mode 6
        for (int m = 4; m <= 6; m += 2) begin
            set_word(13'h100, 16'hFFFF); set_word(13'h101, 16'h0000);
            set_word(13'h102, 16'h0005); set_word(13'h103, 16'h8000);
            run_job(3'(m), 13'h100, 13'h0, 13'h100, 13'd4, 16'h0, -1);
        end

        // Address wrap, IMMADD with saturation on the second element
        set_word(13'h1FFF, 16'h0010); set_word(13'h0000, 16'h7FFF);
        run_job(3'd2, 13'h1FFF, 13'h0, 13'h1FFE, 13'd2, 16'h0001, -1);

        // Write back-pressure on element 1 with a stray go during the stall
        run_job(3'd0, 13'h10, 13'h20, 13'h38, 13'd3, 16'h0, 1);

        // Zero-length job
        run_job(3'd2, 13'h10, 13'h0, 13'h40, 13'd0, 16'h0001, -1);

        // Reset while a write is pending
        prep(3'd0, 13'h10, 13'h20, 13'h90, 13'd3, 16'h0);
        dn0 = done_cnt;
        launch(3'd0, 13'h10, 13'h20, 13'h90, 13'd3, 16'h0);
        n = 0;
        while (!gb_wen && n < 50) begin
            tick();
            n++;
        end
        check_val("rst_reach_wr", 32'(gb_wen), 32'd1);
        rst     = 1'b1;
        gb_wgnt = 1'b0;
        tick();
        check_val("midrst_wen",  32'(gb_wen),   32'd0);
        check_val("midrst_ren",  32'(gb_ren),   32'd0);
        check_val("midrst_busy", 32'(ape_busy), 32'd0);
        check_val("midrst_done", 32'(ape_done), 32'd0);
        rst     = 1'b0;
        gb_wgnt = 1'b1;
        rd_q.delete();
        wr_q.delete();
        for (int i = 0; i < (1 << AW); i++) shadow[i] = mem[i];
        repeat (10) tick();
        check_val("midrst_no_done", 32'(done_cnt - dn0), 32'd0);

        // Recovery after the aborted job
        set_word(13'h200, 16'h1234);
        run_job(3'd2, 13'h200, 13'h0, 13'h201, 13'd1, 16'h0005, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dla_ape_ctrl.md
Name: dla_ape_ctrl

Overview:
- Consumer end of the APE register/staging interface.
- Accepts the `go_comp_ape` pulse and the staged `stgr_ape_*` fields, then runs one APE job of `len` elements on 16-bit fixed-point data:
  - reads source operands from the global buffer (GB);
  - computes the element-wise result in place;
  - writes results back to GB.
- Reports `busy`, a one-cycle `done` pulse, and a dropped-go indication to the control/interrupt logic.

Parameters:
- DW, 16, data word width (signed, two's complement).
- AW, 13, GB word-address width.
- FRAC, 8, fractional bits for multiply modes (Q(DW-FRAC).FRAC).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- go_comp_ape  in  1  start pulse from the register interface.
- stgr_ape_gb_addr_sa  in  AW  source A base address.
- stgr_ape_gb_addr_sb  in  AW  source B base address.
- stgr_ape_gb_addr_d  in  AW  destination base address.
- stgr_ape_len  in  AW  element count.
- stgr_ape_imm  in  DW  immediate operand.
- stgr_ape_mode  in  3  ape_mode_e: ELEADD=0, ELEMUL=1, IMMADD=2, IMMMUL=3, ACTFUNC=4.
- gb_ren  out  1  GB read enable.
- gb_raddr  out  AW  GB read address.
- gb_rdata  in  DW  GB read data, valid exactly 1 cycle after gb_ren.
- gb_wen  out  1  GB write request.
- gb_waddr  out  AW  GB write address.
- gb_wdata  out  DW  GB write data.
- gb_wgnt  in  1  GB write grant; a write completes in the cycle where gb_wen & gb_wgnt.
- ape_busy  out  1  job in progress.
- ape_done  out  1  one-cycle pulse at job end.
- ape_go_drop  out  1  one-cycle pulse when a go arrives while busy.
- ape_perf_cycles  out  32  see Optional Feature.

Behaviour:

Reset:
- All outputs are 0.
- FSM is in IDLE.
- Element counter and operand registers are cleared.
- A reset asserted mid-job aborts the job immediately: no done pulse, and no GB access in the cycle after reset.

Job start:
- In IDLE, go_comp_ape latches sa, sb, d, len, imm and mode into internal job registers, which stay stable for the whole job.
- ape_busy goes to 1 in the next cycle.

Go while busy:
- A go_comp_ape outside IDLE is ignored.
- ape_go_drop pulses 1 cycle later.
- The job registers are not disturbed.

FSM states: IDLE -> RDA -> [RDB] -> CAP -> WR -> (RDA | FIN) -> IDLE.
- RDA: gb_ren=1, gb_raddr=sa+i.
- RDB (ELEADD/ELEMUL only): gb_ren=1, gb_raddr=sb+i; capture A from gb_rdata.
- CAP: capture the last operand (A for IMM/ACT modes, B for ELE modes); compute the result into the result register.
- WR: gb_wen=1, gb_waddr=d+i, gb_wdata=result. Hold all three stable until gb_wgnt=1. On grant, i++. If i==len-1, go to FIN, otherwise go to RDA.
- FIN: ape_done=1 for 1 cycle, ape_busy=0 in the same cycle, then IDLE.

Throughput with gb_wgnt tied to 1:
- 4 cycles per element for ELE modes.
- 3 cycles per element for IMM/ACT modes.

len==0:
- From IDLE go directly to FIN.
- No GB access; done pulses 2 cycles after go.

Address arithmetic:
- All addresses are modulo 2^AW (wrap 8191 -> 0, no error).
- Wrap is independent for sa, sb and d.

Arithmetic:
- ADD modes: 17-bit signed sum, saturated to [-32768, 32767].
- MUL modes: 32-bit signed product, arithmetic shift right by FRAC (truncate toward -inf), saturated to 16 bits.
- IMM modes use imm as operand B.
- ACTFUNC: ReLU. Result = A if A >= 0, else 0.
- Invalid mode encodings 5–7 behave as ACTFUNC.

In-place operation (d == sa):
- Permitted, because element i is read before it is written.
- Overlap with a positive offset (d within sa+1..sa+len-1) is not protected. The result is defined by sequential element order.

Optional Feature:
- Macro APE_PERF_CNT_EN.
- Defined:
  - A 32-bit counter clears on an accepted go and increments every cycle ape_busy=1.
  - Its value is held on ape_perf_cycles until the next accepted go.
  - The counter saturates at 0xFFFFFFFF.
- Undefined: ape_perf_cycles is tied to 0 and no counter flops exist.

Test Plan:
- ELEADD, sa=0x10, sb=0x20, d=0x30, len=3, A={1,2,0x7FFF}, B={3,-5,1}, wgnt=1 -> writes {4,-3,0x7FFF} to 0x30..0x32; done exactly 13 cycles after busy rises.
- IMMMUL, imm=0x0180 (1.5), A={0x0200, 0xFF00, 0x7000} -> {0x0300, 0xFE80, 0x7FFF}; 3 cycles per element.
- ACTFUNC, len=4, A={-1, 0, 5, -32768}, d=sa -> in-place {0, 0, 5, 0}; mode=6 gives the identical result.
- Wrap: sa=0x1FFF, d=0x1FFE, len=2, IMMADD imm=1 -> reads 0x1FFF then 0x0000; writes 0x1FFE then 0x1FFF.
- Back-pressure and stray go: gb_wgnt low for 5 cycles on element 1 -> gb_waddr/gb_wdata held stable, no further reads. A go during the stall -> ape_go_drop pulse, job completes unchanged.
- len=0 -> no gb_ren/gb_wen, done 2 cycles after go. Reset mid-job during WR -> gb_wen=0 the next cycle, no done pulse. With APE_PERF_CNT_EN, ape_perf_cycles equals busy-cycle count (e.g. 13 for the first test).
